// File: rtl/multicycle_control_fsm.sv
// Sequencing control for the multicycle RV32I datapath: per-state enables and
// mux selects, a req/ack memory port with a bus watchdog, and illegal-opcode trapping.
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       branch_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [2:0] imm_src_o,
  output logic       illegal_o,
  output logic       bus_err_o,
  output logic       instr_done_o,
  output logic [3:0] dbg_state_o
);

  // Handshake: mem_req_o rises in FETCH/MEMREAD/MEMWRITE and stays high, with
  // adr_src_o/mem_write_o stable, until a cycle where mem_ack_i is high; that
  // cycle completes the transfer and the FSM moves on at the next edge.

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_LUI      = 4'd9,
    S_AUIPC    = 4'd10,
    S_ALUWB    = 4'd11,
    S_BEQ      = 4'd12,
    S_JALR     = 4'd13,
    S_JUMP     = 4'd14,
    S_TRAP     = 4'd15
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cause_ill_q, cause_ill_d;
  logic          cause_bus_q, cause_bus_d;
  logic          mem_wait;
  logic          timeout;
  logic          skip_ill;

  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cause_ill_q <= 1'b0;
      cause_bus_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_ill_q <= cause_ill_d;
      cause_bus_q <= cause_bus_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    cause_ill_d = cause_ill_q;
    cause_bus_d = cause_bus_q;
    skip_ill    = 1'b0;
    mem_wait    = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    timeout     = (TIMEOUT_CYCLES != 0) && mem_wait && !mem_ack_i && (cnt_q == LIMIT);
    // Counter only runs while a memory state waits; any other cycle leaves it cleared.
    if (mem_wait && !mem_ack_i) cnt_d = cnt_q + CW'(1);

    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (mem_ack_i) state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_OPIMM:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JUMP;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_d     = S_TRAP;
              cause_ill_d = 1'b1;
            end else begin
              state_d  = S_FETCH;
              skip_ill = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR:   state_d = (op_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ack_i) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ack_i) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JALR:     state_d = S_JUMP;
      S_JUMP:     state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d     = S_TRAP;
      cause_bus_d = 1'b1;
    end
  end

  always_comb begin
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    branch_o     = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    imm_src_o    = 3'b000;
    illegal_o    = 1'b0;
    bus_err_o    = 1'b0;
    instr_done_o = 1'b0;
    // Reset forces every output low, including the op-decoded immediate select.
    if (!rst_i) begin
      case (op_i)
        OP_STORE:        imm_src_o = 3'b001;
        OP_BRANCH:       imm_src_o = 3'b010;
        OP_JAL:          imm_src_o = 3'b011;
        OP_LUI, OP_AUIPC: imm_src_o = 3'b100;
        default:         imm_src_o = 3'b000;
      endcase
      instr_done_o = (state_d == S_FETCH) && (state_q != S_IDLE) &&
                     (state_q != S_FETCH) && !skip_ill;
      case (state_q)
        S_FETCH: begin
          mem_req_o    = 1'b1;
          alu_src_b_o  = 2'b10;
          result_src_o = 2'b10;
          ir_write_o   = mem_ack_i;
          pc_write_o   = mem_ack_i;
        end
        S_DECODE: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b01;
          illegal_o   = skip_ill;
        end
        S_MEMADR, S_EXECI, S_JALR: begin
          alu_src_a_o = 2'b10;
          alu_src_b_o = 2'b01;
          if (state_q == S_EXECI) alu_op_o = 2'b10;
        end
        S_MEMREAD: begin
          mem_req_o = 1'b1;
          adr_src_o = 1'b1;
        end
        S_MEMWB: begin
          result_src_o = 2'b01;
          reg_write_o  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req_o   = 1'b1;
          mem_write_o = 1'b1;
          adr_src_o   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a_o = 2'b10;
          alu_op_o    = 2'b10;
        end
        S_LUI: begin
          alu_src_a_o = 2'b11;
          alu_src_b_o = 2'b01;
        end
        S_AUIPC: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b01;
        end
        S_ALUWB:  reg_write_o = 1'b1;
        S_BEQ: begin
          alu_src_a_o = 2'b10;
          alu_op_o    = 2'b01;
          branch_o    = 1'b1;
        end
        S_JUMP: begin
          pc_write_o  = 1'b1;
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b10;
        end
        S_TRAP: begin
          illegal_o = cause_ill_q;
          bus_err_o = cause_bus_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a default instance and one with
// illegal-skip and a 4-cycle watchdog, checked cycle by cycle via an expected queue.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       mreq, mw, adr, irw, pcw, br, rw;
    logic [1:0] rs, a, b, aop;
    logic [2:0] imm;
    logic       ill, be, done;
  } out_t;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] OI  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] AU  = 7'b0010111;
  localparam logic [6:0] ILL = 7'b1111111;

  logic       clk;
  logic       rst_a, rst_b;
  logic [6:0] op_i;
  logic       ack_i;

  logic       mreq_a, mw_a, adr_a, irw_a, pcw_a, br_a, rw_a, ill_a, be_a, done_a;
  logic [1:0] rs_a, sa_a, sb_a, aop_a;
  logic [2:0] imm_a;
  logic [3:0] st_a;
  logic       mreq_b, mw_b, adr_b, irw_b, pcw_b, br_b, rw_b, ill_b, be_b, done_b;
  logic [1:0] rs_b, sa_b, sb_b, aop_b;
  logic [2:0] imm_b;
  logic [3:0] st_b;
  logic [20:0] obs_a, obs_b;

  logic [20:0] exp_q[$];
  int compared;
  int mismatched;

  multicycle_control_fsm dut_a (
    .clk_i(clk), .rst_i(rst_a), .op_i(op_i), .mem_ack_i(ack_i),
    .mem_req_o(mreq_a), .mem_write_o(mw_a), .adr_src_o(adr_a), .ir_write_o(irw_a),
    .pc_write_o(pcw_a), .branch_o(br_a), .reg_write_o(rw_a), .result_src_o(rs_a),
    .alu_src_a_o(sa_a), .alu_src_b_o(sb_a), .alu_op_o(aop_a), .imm_src_o(imm_a),
    .illegal_o(ill_a), .bus_err_o(be_a), .instr_done_o(done_a), .dbg_state_o(st_a)
  );

  multicycle_control_fsm #(.TIMEOUT_CYCLES(4), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .op_i(op_i), .mem_ack_i(ack_i),
    .mem_req_o(mreq_b), .mem_write_o(mw_b), .adr_src_o(adr_b), .ir_write_o(irw_b),
    .pc_write_o(pcw_b), .branch_o(br_b), .reg_write_o(rw_b), .result_src_o(rs_b),
    .alu_src_a_o(sa_b), .alu_src_b_o(sb_b), .alu_op_o(aop_b), .imm_src_o(imm_b),
    .illegal_o(ill_b), .bus_err_o(be_b), .instr_done_o(done_b), .dbg_state_o(st_b)
  );

  assign obs_a = {mreq_a, mw_a, adr_a, irw_a, pcw_a, br_a, rw_a, rs_a, sa_a, sb_a, aop_a,
                  imm_a, ill_a, be_a, done_a};
  assign obs_b = {mreq_b, mw_b, adr_b, irw_b, pcw_b, br_b, rw_b, rs_b, sa_b, sb_b, aop_b,
                  imm_b, ill_b, be_b, done_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vectors per state, straight from the state/output table.
  function automatic out_t o0(input logic [2:0] imm);
    out_t r;
    r = '0;
    r.imm = imm;
    return r;
  endfunction

  function automatic out_t fetch(input logic ack, input logic [2:0] imm);
    out_t r;
    r = o0(imm); r.mreq = 1'b1; r.b = 2'b10; r.rs = 2'b10; r.irw = ack; r.pcw = ack;
    return r;
  endfunction

  function automatic out_t decode(input logic [2:0] imm, input logic ill);
    out_t r;
    r = o0(imm); r.a = 2'b01; r.b = 2'b01; r.ill = ill;
    return r;
  endfunction

  function automatic out_t a_b(input logic [2:0] imm, input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] aop);
    out_t r;
    r = o0(imm); r.a = a; r.b = b; r.aop = aop;
    return r;
  endfunction

  function automatic out_t memrd(input logic [2:0] imm);
    out_t r;
    r = o0(imm); r.mreq = 1'b1; r.adr = 1'b1;
    return r;
  endfunction

  function automatic out_t memwr(input logic [2:0] imm, input logic ack);
    out_t r;
    r = o0(imm); r.mreq = 1'b1; r.mw = 1'b1; r.adr = 1'b1; r.done = ack;
    return r;
  endfunction

  function automatic out_t wb(input logic [2:0] imm, input logic [1:0] rs);
    out_t r;
    r = o0(imm); r.rw = 1'b1; r.rs = rs; r.done = 1'b1;
    return r;
  endfunction

  function automatic out_t beq(input logic [2:0] imm);
    out_t r;
    r = o0(imm); r.a = 2'b10; r.aop = 2'b01; r.br = 1'b1; r.done = 1'b1;
    return r;
  endfunction

  function automatic out_t jump(input logic [2:0] imm);
    out_t r;
    r = o0(imm); r.pcw = 1'b1; r.a = 2'b01; r.b = 2'b10;
    return r;
  endfunction

  function automatic out_t trap(input logic ill, input logic be);
    out_t r;
    r = o0(3'b000); r.ill = ill; r.be = be;
    return r;
  endfunction

  task automatic step(input bit sel, input logic [6:0] op, input logic ack, input logic rst,
                      input out_t e, input string tag);
    logic [20:0] ex, ob;
    op_i  = op;
    ack_i = ack;
    if (sel) rst_b = rst;
    else     rst_a = rst;
    exp_q.push_back(e);
    @(negedge clk);
    ex = exp_q.pop_front();
    ob = sel ? obs_b : obs_a;
    compared++;
    assert (ob === ex) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, ob, ex);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    op_i  = LD;
    ack_i = 1'b1;

    // Load, zero-wait
    step(0, LD, 1, 1, o0(3'b000), "rst_hold0");
    step(0, LD, 1, 1, o0(3'b000), "rst_hold1");
    compared++;
    assert (st_a === 4'd0) else begin
      mismatched++;
      $error("FAIL rst_state: observed %h expected %h", st_a, 4'd0);
    end
    step(0, LD, 1, 0, o0(3'b000), "idle");
    step(0, LD, 1, 0, fetch(1, 3'b000), "ld_fetch");
    step(0, LD, 1, 0, decode(3'b000, 0), "ld_decode");
    step(0, LD, 1, 0, a_b(3'b000, 2'b10, 2'b01, 2'b00), "ld_memadr");
    step(0, LD, 1, 0, memrd(3'b000), "ld_memread");
    step(0, LD, 1, 0, wb(3'b000, 2'b01), "ld_memwb");

    // Store with three wait cycles in MEMWRITE
    step(0, ST, 1, 0, fetch(1, 3'b001), "st_fetch");
    step(0, ST, 1, 0, decode(3'b001, 0), "st_decode");
    step(0, ST, 1, 0, a_b(3'b001, 2'b10, 2'b01, 2'b00), "st_memadr");
    for (int i = 0; i < 3; i++) step(0, ST, 0, 0, memwr(3'b001, 0), "st_memwrite_wait");
    step(0, ST, 1, 0, memwr(3'b001, 1), "st_memwrite_ack");

    // JALR
    step(0, JR, 1, 0, fetch(1, 3'b000), "jalr_fetch");
    step(0, JR, 1, 0, decode(3'b000, 0), "jalr_decode");
    step(0, JR, 1, 0, a_b(3'b000, 2'b10, 2'b01, 2'b00), "jalr_jalr");
    step(0, JR, 1, 0, jump(3'b000), "jalr_jump");
    step(0, JR, 1, 0, wb(3'b000, 2'b00), "jalr_aluwb");

    // AUIPC
    step(0, AU, 1, 0, fetch(1, 3'b100), "auipc_fetch");
    step(0, AU, 1, 0, decode(3'b100, 0), "auipc_decode");
    step(0, AU, 1, 0, a_b(3'b100, 2'b01, 2'b01, 2'b00), "auipc_auipc");
    step(0, AU, 1, 0, wb(3'b100, 2'b00), "auipc_aluwb");

    // Branch
    step(0, BR, 1, 0, fetch(1, 3'b010), "beq_fetch");
    step(0, BR, 1, 0, decode(3'b010, 0), "beq_decode");
    step(0, BR, 1, 0, beq(3'b010), "beq_beq");

    // R-type with one fetch wait cycle
    step(0, RT, 0, 0, fetch(0, 3'b000), "r_fetch_wait");
    step(0, RT, 1, 0, fetch(1, 3'b000), "r_fetch");
    step(0, RT, 1, 0, decode(3'b000, 0), "r_decode");
    step(0, RT, 1, 0, a_b(3'b000, 2'b10, 2'b00, 2'b10), "r_execr");
    step(0, RT, 1, 0, wb(3'b000, 2'b00), "r_aluwb");

    // JAL
    step(0, JL, 1, 0, fetch(1, 3'b011), "jal_fetch");
    step(0, JL, 1, 0, decode(3'b011, 0), "jal_decode");
    step(0, JL, 1, 0, jump(3'b011), "jal_jump");
    step(0, JL, 1, 0, wb(3'b011, 2'b00), "jal_aluwb");

    // Op-imm and LUI
    step(0, OI, 1, 0, fetch(1, 3'b000), "oi_fetch");
    step(0, OI, 1, 0, decode(3'b000, 0), "oi_decode");
    step(0, OI, 1, 0, a_b(3'b000, 2'b10, 2'b01, 2'b10), "oi_execi");
    step(0, OI, 1, 0, wb(3'b000, 2'b00), "oi_aluwb");
    step(0, LU, 1, 0, fetch(1, 3'b100), "lui_fetch");
    step(0, LU, 1, 0, decode(3'b100, 0), "lui_decode");
    step(0, LU, 1, 0, a_b(3'b100, 2'b11, 2'b01, 2'b00), "lui_lui");
    step(0, LU, 1, 0, wb(3'b100, 2'b00), "lui_aluwb");

    // Reset in the middle of a fetch wait
    step(0, LD, 0, 0, fetch(0, 3'b000), "midwait_fetch");
    step(0, LD, 0, 1, o0(3'b000), "midwait_rst");
    step(0, LD, 0, 0, o0(3'b000), "midwait_idle");

    // Illegal opcode traps and sticks until reset
    step(0, ILL, 1, 0, fetch(1, 3'b000), "ill_fetch");
    step(0, ILL, 1, 0, decode(3'b000, 0), "ill_decode");
    for (int i = 0; i < 20; i++) step(0, ILL, (i % 2) == 0, 0, trap(1, 0), "ill_trap");
    step(0, ILL, 1, 1, o0(3'b000), "ill_rst");
    step(0, LD, 1, 0, o0(3'b000), "ill_idle");
    step(0, LD, 1, 0, fetch(1, 3'b000), "ill_refetch");

    // Second instance: skipped illegal, then watchdog
    rst_a = 1'b1;
    step(1, ILL, 1, 1, o0(3'b000), "b_rst");
    step(1, ILL, 1, 0, o0(3'b000), "b_idle");
    step(1, ILL, 1, 0, fetch(1, 3'b000), "b_ill_fetch");
    step(1, ILL, 1, 0, decode(3'b000, 1), "b_ill_skip");
    for (int i = 0; i < 4; i++) step(1, ILL, 0, 0, fetch(0, 3'b000), "b_to_fetch");
    for (int i = 0; i < 3; i++) step(1, ILL, 0, 0, trap(0, 1), "b_to_trap");
    step(1, RT, 0, 1, o0(3'b000), "b_to_rst");
    step(1, RT, 0, 0, o0(3'b000), "b_idle2");
    for (int i = 0; i < 3; i++) step(1, RT, 0, 0, fetch(0, 3'b000), "b_limit_wait");
    step(1, RT, 1, 0, fetch(1, 3'b000), "b_limit_ack");
    step(1, RT, 1, 0, decode(3'b000, 0), "b_limit_decode");
    step(1, RT, 1, 0, a_b(3'b000, 2'b10, 2'b00, 2'b10), "b_execr");
    step(1, RT, 1, 0, wb(3'b000, 2'b00), "b_aluwb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
